// File: rtl/mux_pipe_pkg.sv
// Shared encodings and default sizes for the registered N-input selector.
package mux_pipe_pkg;

   // Selection mode as presented on the sel_mode pin
   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } sel_mode_e;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_NUM_IN = 5;

endpackage : mux_pipe_pkg

// File: rtl/mux_pipe_n_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting channel after the last
// winner, wrapping NUM_IN-1 -> 0. The pointer only moves when the granted
// beat is actually taken (advance), so idle or stalled cycles keep fairness.
module rr_arbiter #(
   parameter  int NUM_IN = 5,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_IN-1:0] req,
   input  logic              advance,
   output logic [NUM_IN-1:0] grant,
   output logic [SEL_W-1:0]  idx,
   output logic              found
);

   logic [SEL_W-1:0] ptr;

   // Search the request vector starting just after the last winner
   always_comb begin
      int c;
      // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_IN; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_IN) c = c - NUM_IN;
         if (!found && req[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = c[SEL_W-1:0];
         end
      end
   end

   // Remember the last winner; reset value makes channel 0 win first
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr <= SEL_W'(NUM_IN - 1);
      end else if (advance) begin
         // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
         ptr <= idx;
      end
   end

endmodule : rr_arbiter

// File: rtl/mux_pipe_n.sv
// Registered N-input valid/ready selector with a one-entry output slot.
// Channel chosen by explicit index, or by round-robin when MUX_PIPE_RR_EN
// is defined (otherwise sel_mode is ignored and no arbiter is built).
// Out-of-range explicit selects grant nothing and set a sticky err_sel.
module mux_pipe_n
   import mux_pipe_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int NUM_IN = DEF_NUM_IN,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic                    sel_mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_chan,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err_sel,
   input  logic                    err_clr
);

   // One extra bit so the range compare cannot wrap when NUM_IN is a power of two
   localparam logic [SEL_W:0] NUM_IN_X = (SEL_W + 1)'(NUM_IN);

   logic              load;
   logic              mode_rr;
   logic              sel_ok;
   logic              sel_bad;
   logic              transfer;
   logic [SEL_W-1:0]  g_idx;
   logic [WIDTH-1:0]  g_data;
   logic [NUM_IN-1:0] sel_onehot;
   logic [NUM_IN-1:0] arb_grant;
   logic [SEL_W-1:0]  arb_idx;
   logic              arb_found;

`ifdef MUX_PIPE_RR_EN
   assign mode_rr = (sel_mode == MODE_RR);

   rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
      .clock   (clock),
      .reset   (reset),
      .req     (in_valid),
      .advance (transfer & mode_rr),
      .grant   (arb_grant),
      .idx     (arb_idx),
      .found   (arb_found)
   );
`else
   logic unused_sel_mode;
   assign unused_sel_mode = sel_mode;
   assign mode_rr   = 1'b0;
   assign arb_grant = '0;
   assign arb_idx   = '0;
   assign arb_found = 1'b0;
`endif

   // Grant selection, handshake and data steering
   always_comb begin
      sel_ok  = ({1'b0, sel} < NUM_IN_X);
      sel_bad = !mode_rr && !sel_ok;
      for (int i = 0; i < NUM_IN; i++) begin
         sel_onehot[i] = sel_ok && (sel == SEL_W'(i));
      end
      g_idx    = mode_rr ? arb_idx : sel;
      load     = !out_valid || out_ready;
      in_ready = (mode_rr ? arb_grant : sel_onehot) & {NUM_IN{load}};
      transfer = |(in_ready & in_valid);
      g_data   = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (g_idx == SEL_W'(i)) g_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Output slot: load on transfer, empty when drained, hold under stall
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (transfer) begin
         out_valid <= 1'b1;
         out_data  <= g_data;
         out_chan  <= g_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky select error; a new violation beats a same-cycle clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_sel <= 1'b0;
      end else if (sel_bad) begin
         err_sel <= 1'b1;
      end else if (err_clr) begin
         err_sel <= 1'b0;
      end
   end

`ifdef MUX_PIPE_RR_EN
   // rr_ptr lives inside the arbiter; the explicit path has no extra state
`endif

endmodule : mux_pipe_n
